msrv32_ls_ctrl: RTL

Load/store bus sequencer that sits between the execute stage and the AHB-Lite data port.
- Accepts one load or store request at a time and checks alignment.
- Runs the AHB address phase and data phase, including wait states and error responses.
- Generates lane-replicated store data and byte strobes.
- Holds the load-unit sideband (size, sign, address offset, response) stable so the load unit's output is valid when completion is signalled.
- Stalls the pipeline while a transfer is outstanding.

---
 rtl/msrv32_ls_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/msrv32_ls_ctrl.sv
// Load/store sequencer between the execute stage and the AHB-Lite data port.
// Takes one request at a time, checks alignment, runs address/data phases and reports completion.
module msrv32_ls_ctrl #(
   parameter int ADDR_W = 32
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              req_valid_in,
   output logic              req_ready_out,
   input  logic              req_is_store_in,
   input  logic [ADDR_W-1:0] req_addr_in,
   input  logic [1:0]        req_size_in,
   input  logic              req_unsigned_in,
   input  logic [31:0]       req_wdata_in,
   output logic [ADDR_W-1:0] haddr_out,
   output logic [1:0]        htrans_out,
   output logic              hwrite_out,
   output logic [2:0]        hsize_out,
   output logic [31:0]       hwdata_out,
   output logic [3:0]        wr_mask_out,
   input  logic              hready_in,
   input  logic              hresp_in,
   output logic [1:0]        lu_load_size_out,
   output logic              lu_load_unsigned_out,
   output logic [1:0]        lu_iadder_1_to_0_out,
   output logic              lu_ahb_resp_out,
   output logic              stall_out,
   output logic              done_out,
   output logic              err_out,
   output logic              misaligned_out
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADDR = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;
   localparam logic [1:0] S_MERR = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        size_q, size_d;
   logic              unsigned_q, unsigned_d;
   logic              store_q, store_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        mask_q, mask_d;

   logic              accept;
   logic              misaligned;
   logic [31:0]       lane_data;
   logic [3:0]        lane_mask;

   assign accept     = req_valid_in && (state_q == S_IDLE);
   assign misaligned = ((req_size_in == 2'b01) && req_addr_in[0]) ||
                       (req_size_in[1] && (req_addr_in[1:0] != 2'b00));

   // Store data is replicated across all lanes so the slave can pick any byte lane.
   always_comb begin
      lane_data = req_wdata_in;
      lane_mask = 4'b1111;
      case (req_size_in)
         2'b00: begin
            lane_data = {4{req_wdata_in[7:0]}};
            lane_mask = 4'b0001 << req_addr_in[1:0];
         end
         2'b01: begin
            lane_data = {2{req_wdata_in[15:0]}};
            lane_mask = 4'b0011 << {req_addr_in[1], 1'b0};
         end
         default: begin
            lane_data = req_wdata_in;
            lane_mask = 4'b1111;
         end
      endcase
      if (!req_is_store_in) begin
         lane_mask = 4'b0000;
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      size_d     = size_q;
      unsigned_d = unsigned_q;
      store_d    = store_q;
      wdata_d    = wdata_q;
      mask_d     = mask_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               addr_d     = req_addr_in;
               size_d     = req_size_in;
               unsigned_d = req_unsigned_in;
               store_d    = req_is_store_in;
               wdata_d    = lane_data;
               mask_d     = lane_mask;
               state_d    = misaligned ? S_MERR : S_ADDR;
            end
         end
         S_ADDR:  if (hready_in) state_d = S_DATA;
         S_DATA:  if (hready_in) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         size_q     <= 2'b00;
         unsigned_q <= 1'b0;
         store_q    <= 1'b0;
         wdata_q    <= 32'h0;
         mask_q     <= 4'b0000;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         size_q     <= size_d;
         unsigned_q <= unsigned_d;
         store_q    <= store_d;
         wdata_q    <= wdata_d;
         mask_q     <= mask_d;
      end
   end

   assign req_ready_out        = (state_q == S_IDLE);
   assign stall_out            = (state_q != S_IDLE) || req_valid_in;
   assign htrans_out           = (state_q == S_ADDR) ? 2'b10 : 2'b00;
   assign haddr_out            = addr_q;
   assign hwrite_out           = store_q;
   // Size 11 is a word, same as the load unit's view.
   assign hsize_out            = size_q[1] ? 3'b010 : {2'b00, size_q[0]};
   assign hwdata_out           = wdata_q;
   assign wr_mask_out          = mask_q;
   assign lu_load_size_out     = size_q;
   assign lu_load_unsigned_out = unsigned_q;
   assign lu_iadder_1_to_0_out = addr_q[1:0];
   assign lu_ahb_resp_out      = (state_q == S_DATA) && hresp_in;
   assign done_out             = (state_q == S_MERR) || ((state_q == S_DATA) && hready_in);
   assign err_out              = (state_q == S_MERR) || ((state_q == S_DATA) && hready_in && hresp_in);
   assign misaligned_out       = (state_q == S_MERR);

endmodule
